// File: rtl/neurocore.sv
// neurocore: four leaky integrate-and-fire neurons, each fully connected to
// four binary input spike lines through a signed 4x4 weight matrix.
// A shared threshold and leak are programmed over the pin interface.
// One network timestep is evaluated per strobe cycle.
module neurocore (
  input  logic       clk,
  input  logic       rst_n,   // asynchronous, active-HIGH despite the name
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Weight matrix indexed [neuron][input]; each entry is a signed byte.
  logic [3:0][3:0][7:0] w_q, w_d;
  logic [7:0]           thr_q, thr_d;
  logic [7:0]           leak_q, leak_d;
  logic [3:0][7:0]      v_q, v_d;
  logic [3:0]           spk_q, spk_d;

  // Per-neuron result of a step: {fired, new membrane}.
  logic [3:0][8:0]      step_res_s;

  logic       we_s;
  logic [5:0] addr_s;
  logic       strobe_s;
  logic       unused_s;

  assign we_s     = uio_in[7];
  assign addr_s   = uio_in[5:0];
  assign strobe_s = ui_in[7];

  // Tile enable and the spare control bit carry no function.
  assign unused_s = &{1'b0, ena, uio_in[6]};

  // One LIF update: integrate weighted spikes, subtract leak, clamp to a
  // byte, then fire-and-reset when the clamped value reaches threshold.
  // Twelve signed bits cover the worst case 255 + 4*127 and 0 - 4*128 - 255.
  function automatic logic [8:0] lif_step(
    input logic [7:0]      v,
    input logic [3:0][7:0] w,
    input logic [3:0]      s,
    input logic [7:0]      leak,
    input logic [7:0]      thr
  );
    logic signed [11:0] sum;
    logic [7:0]         vc;
    sum = $signed({4'b0000, v});
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        sum = sum + $signed({{4{w[i][7]}}, w[i]});
      end else begin
        sum = sum;
      end
    end
    sum = sum - $signed({4'b0000, leak});
    if (sum < 12'sd0) begin
      vc = 8'h00;
    end else if (sum > 12'sd255) begin
      vc = 8'hFF;
    end else begin
      vc = sum[7:0];
    end
    if (vc >= thr) begin
      return {1'b1, 8'h00};
    end else begin
      return {1'b0, vc};
    end
  endfunction

  // Evaluate the candidate step result for every neuron in parallel.
  always_comb begin
    step_res_s = {4{9'h000}};
    for (int n = 0; n < 4; n++) begin
      step_res_s[n] = lif_step(v_q[n], w_q[n], ui_in[3:0], leak_q, thr_q);
    end
  end

  // Next-state: config write has priority over a step; otherwise hold.
  always_comb begin
    w_d    = w_q;
    thr_d  = thr_q;
    leak_d = leak_q;
    v_d    = v_q;
    spk_d  = spk_q;
    if (we_s) begin
      if (addr_s < 6'd16) begin
        w_d[addr_s[3:2]][addr_s[1:0]] = ui_in;
      end else if (addr_s == 6'd16) begin
        thr_d = ui_in;
      end else if (addr_s == 6'd17) begin
        leak_d = ui_in;
      end else begin
        thr_d = thr_q;
      end
    end else if (strobe_s) begin
      for (int n = 0; n < 4; n++) begin
        v_d[n]   = step_res_s[n][7:0];
        spk_d[n] = step_res_s[n][8];
      end
    end else begin
      spk_d = spk_q;
    end
  end

  // State registers with asynchronous reset to the power-on configuration.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      w_q    <= {16{8'h00}};
      thr_q  <= 8'h80;
      leak_q <= 8'h00;
      v_q    <= {4{8'h00}};
      spk_q  <= 4'b0000;
    end else begin
      w_q    <= w_d;
      thr_q  <= thr_d;
      leak_q <= leak_d;
      v_q    <= v_d;
      spk_q  <= spk_d;
    end
  end

  // Spike vector is registered; the membrane probe follows the select live.
  assign uo_out  = {v_q[ui_in[6:5]][7:4], spk_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_neurocore.sv
`timescale 1ns/1ps
module tb_neurocore;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept as plain integers.
  int         wm [4][4];
  int         thr_m;
  int         leak_m;
  int         vm [4];
  logic [3:0] spk_m;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;
  exp_t sbq[$];

  neurocore dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      vm[n] = 0;
      for (int i = 0; i < 4; i++) wm[n][i] = 0;
    end
    thr_m  = 128;
    leak_m = 0;
    spk_m  = 4'b0000;
  endtask

  function automatic logic [7:0] model_out(input logic [1:0] sel);
    logic [7:0] v;
    v = vm[sel][7:0];
    return {v[7:4], spk_m};
  endfunction

  // One clock cycle of stimulus: drive inputs, advance the model, and queue
  // the uo_out value expected right after the coming rising edge.
  task automatic cyc(input logic we, input logic [5:0] addr, input logic [7:0] ui, input string name);
    int s;
    logic [7:0] spare;
    @(negedge clk);
    spare  = 8'($urandom);
    ui_in  = ui;
    uio_in = {we, spare[6], addr};
    if (we) begin
      if (addr < 6'd16) wm[addr[3:2]][addr[1:0]] = $signed(ui);
      else if (addr == 6'd16) thr_m = ui;
      else if (addr == 6'd17) leak_m = ui;
    end else if (ui[7]) begin
      for (int n = 0; n < 4; n++) begin
        s = vm[n];
        for (int i = 0; i < 4; i++) if (ui[i]) s += wm[n][i];
        s -= leak_m;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        if (s >= thr_m) begin
          spk_m[n] = 1'b1;
          vm[n]    = 0;
        end else begin
          spk_m[n] = 1'b0;
          vm[n]    = s;
        end
      end
    end
    sbq.push_back('{model_out(ui[6:5]), name});
  endtask

  // Assert reset between edges with random inputs; outputs must clear at once.
  task automatic async_reset(input string name);
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    #1;
    chk({name, "_uo"}, uo_out, 8'h00);
    chk({name, "_uio_out"}, uio_out, 8'h00);
    chk({name, "_uio_oe"}, uio_oe, 8'h00);
    model_reset();
    for (int s = 0; s < 4; s++) begin
      ui_in[6:5] = 2'(s);
      #1;
      chk({name, "_probe"}, uo_out, 8'h00);
    end
    @(negedge clk);
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b0;
  endtask

  // Monitor: every cycle with a queued expectation is compared after the edge.
  initial begin
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        it = sbq.pop_front();
        chk(it.name, uo_out, it.exp);
        chk({it.name, "_uio_oe"}, uio_oe, 8'h00);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       we;
    logic [5:0] addr;
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();

    async_reset("reset");

    // Integrate and fire.
    cyc(1'b1, 6'd0,  8'd50,  "wr_w00");
    cyc(1'b1, 6'd16, 8'd100, "wr_thr");
    cyc(1'b1, 6'd17, 8'd0,   "wr_leak");
    cyc(1'b0, 6'd0,  8'h81,  "if_step1");
    cyc(1'b0, 6'd0,  8'h81,  "if_step2");
    cyc(1'b0, 6'd0,  8'h81,  "if_step3");

    // Leak and floor clamp.
    cyc(1'b1, 6'd17, 8'd20,  "wr_leak20");
    cyc(1'b0, 6'd0,  8'h80,  "leak_step1");
    cyc(1'b0, 6'd0,  8'h80,  "leak_step2");
    cyc(1'b1, 6'd1,  8'h9C,  "wr_w01");
    cyc(1'b0, 6'd0,  8'h82,  "floor_clamp");

    // Saturation on neuron 1.
    cyc(1'b1, 6'd16, 8'd255, "wr_thr255");
    for (int a = 4; a < 8; a++) cyc(1'b1, 6'(a), 8'd127, "wr_w1x");
    cyc(1'b0, 6'd0,  8'hAF,  "saturate");

    // Write/step exclusivity and ignored addresses.
    cyc(1'b1, 6'd16, 8'h85,  "we_with_strobe");
    cyc(1'b1, 6'd40, 8'hFF,  "addr40");
    for (int s = 0; s < 4; s++) cyc(1'b0, 6'd0, {1'b0, 2'(s), 5'b0}, "probe");

    // Spike, then async reset mid-run; threshold must return to 0x80.
    cyc(1'b1, 6'd16, 8'd1,   "wr_thr1");
    cyc(1'b0, 6'd0,  8'h81,  "pre_reset_spike");
    async_reset("midrun_reset");
    cyc(1'b1, 6'd0,  8'd100, "wr_w00_100");
    cyc(1'b0, 6'd0,  8'h81,  "thr_default1");
    cyc(1'b0, 6'd0,  8'h81,  "thr_default2");

    // Randomized traffic, including held strobes and stray addresses.
    for (int k = 0; k < 400; k++) begin
      we   = ($urandom_range(0, 3) == 0);
      addr = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(18, 63)) : 6'($urandom_range(0, 17));
      cyc(we, addr, 8'($urandom), "random");
      if (k == 200) async_reset("random_reset");
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neurocore.md
# neurocore

Small spiking neural-network core for a TinyTapeout tile: four leaky integrate-and-fire (LIF) neurons, each fully connected to four binary input spike lines through a programmable signed 4×4 weight matrix. The core has a shared firing threshold and a shared leak. Weights and parameters are loaded over the pin interface. The network advances one timestep per strobe. The module is the top-level tile user module; the cleaned name used here is `neurocore`.

## Interface
- Parameters: none.
- `clk` in 1: single system clock; all state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-high reset. Despite the name, `rst_n`=1 clears all state immediately.
- `ena` in 1: tile enable; ignored.
- `ui_in` in 8: multiplexed input.
  - Config mode: write data.
  - Run mode: [3:0] input spikes s0..s3; [6:5] membrane-probe neuron select; [7] step strobe; [4] unused.
- `uio_in` in 8: control. [7] `we` (config write enable); [5:0] `addr`; [6] unused.
- `uo_out` out 8: [3:0] registered spike vector of the last step; [7:4] membrane[sel][7:4].
- `uio_out` out 8: constant 0.
- `uio_oe` out 8: constant 0 (all uio pins are inputs).

## Operation
**State**
- W[n][i]: 16 signed 8-bit weights.
- THR: unsigned 8-bit threshold.
- LEAK: unsigned 8-bit leak.
- V[n]: 4 unsigned 8-bit membranes.
- SPK[3:0]: spike register.

**Reset values**
- W=0, THR=0x80, LEAK=0x00, V=0, SPK=0.
- Resulting outputs: `uo_out`=0x00, `uio_out`=0, `uio_oe`=0.

**Config write** (`we`=1, on the clock edge)
- `addr` 0..15: W[addr[3:2]][addr[1:0]] ← `ui_in`.
- `addr` 16: THR ← `ui_in`.
- `addr` 17: LEAK ← `ui_in`.
- `addr` 18..63: write ignored.
- V and SPK are unchanged during a write, and no step occurs while `we`=1, even if `ui_in[7]`=1.

**Step** (`we`=0 and `ui_in[7]`=1, on the clock edge), evaluated for each neuron n in parallel:
- sum = V[n] + Σ_i (s_i ? W[n][i] : 0) − LEAK, computed as signed 12-bit with no intermediate overflow.
- vc = clamp(sum, 0, 255).
- If vc ≥ THR (unsigned compare): SPK[n] ← 1 and V[n] ← 0.
- Otherwise: SPK[n] ← 0 and V[n] ← vc.
- THR=0 therefore makes every neuron fire on every step.

**Idle** (`we`=0, `ui_in[7]`=0)
- All state holds.
- SPK holds the result of the last step.

**Probe output**
- `uo_out[7:4]` is combinational: V[`ui_in[6:5]`][7:4].
- It reflects the current register value and may change with `ui_in[6:5]` at any time.

## Timing
- Write latency: the new value is used by a step no earlier than the next edge; a step on the edge immediately after the write sees the new value.
- Step latency: SPK and V update on the strobe edge and are visible on `uo_out` directly after that edge.
- Each cycle with the strobe high is one step, so a strobe held high for k cycles performs k steps.
- Async reset asserted mid-step forces all reset values immediately, without waiting for a clock; the first step after deassertion starts from V=0.
- No handshake and no busy state: every timestep completes in one cycle.

## Test plan
- **Reset:** assert `rst_n`=1 with random inputs → `uo_out`=0x00, `uio_oe`=0x00, `uio_out`=0x00; probe of each neuron reads 0.
- **Integrate and fire:**
  - Stimulus: write W[0][0]=50 (addr 0), THR=100 (addr 16), LEAK=0; then three steps with `ui_in`=0x81.
  - After step 1: `uo_out[3:0]`=0000, V0=50.
  - After step 2: `uo_out[3:0]`=0001 and V0=0.
  - After step 3: `uo_out[3:0]`=0000 and V0=50 (probe reads 0x3).
- **Leak and floor clamp:**
  - Stimulus: LEAK=20, V0=50, then two steps with no input spikes.
  - Required: V0=30, then V0=10.
  - Then W[0][1]=−100 (0x9C) and a step with s1=1 → V0 clamps to 0, no spike.
- **Saturation:**
  - Stimulus: THR=255, W[1][0..3]=127, one step with all spikes (`ui_in`=0x8F).
  - Required: V1 clamps to 255 ≥ THR → SPK[1]=1 and V1=0.
- **Write/step exclusivity:** `we`=1 with `ui_in[7]`=1 → register written, V and SPK unchanged; `addr` 40 write → no state changes.
- **Async reset mid-run:** after a spike, assert `rst_n` between clock edges → `uo_out` goes to 0 before the next edge, and THR returns to 0x80.
